// File: rtl/dcache_wt_ctrl_pkg.sv
// Shared definitions for the write-through data cache controller.
// These are the controller state encodings and the default geometry.
package dcache_wt_ctrl_pkg;

    localparam int DC_ADDR_W = 7;
    localparam int DC_DATA_W = 32;
    localparam int DC_IDX_W  = 3;
    localparam int DC_CNT_W  = 16;

    typedef enum logic [1:0] {
        DC_IDLE  = 2'd0,
        DC_RMISS = 2'd1,
        DC_WRITE = 2'd2,
        DC_DONE  = 2'd3
    } dc_state_e;

endpackage

// File: rtl/dcache_line_array.sv
// Direct-mapped line storage: valid/tag/data per line, combinational read port,
// one synchronous write port. Only the valid vector is reset.
module dcache_line_array #(
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i
);
    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data carry no reset; the valid bit guards them.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits complete in-cycle; misses and every store stall until mem_ready.
module dcache_wt_ctrl
    import dcache_wt_ctrl_pkg::*;
#(
    parameter int ADDR_W = DC_ADDR_W,
    parameter int DATA_W = DC_DATA_W,
    parameter int IDX_W  = DC_IDX_W,
    parameter int CNT_W  = DC_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    dc_state_e state_q, state_d;

    logic              mem_read_q, mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

    logic [ADDR_W-1:0] lk_addr;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic              hit;

    logic              line_we;
    logic [DATA_W-1:0] line_wdata;
    logic              issue_rd, issue_wr, count_hit;

    // Outside IDLE the lookup uses the latched request address.
    assign lk_addr = (state_q == DC_IDLE) ? cpu_addr : mem_addr_q;
    assign hit     = line_valid && (line_tag == lk_addr[ADDR_W-1:IDX_W]);

    dcache_line_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .DATA_W(DATA_W)
    ) u_lines (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx_i  (lk_addr[IDX_W-1:0]),
        .rd_valid_o(line_valid),
        .rd_tag_o  (line_tag),
        .rd_data_o (line_data),
        .we_i      (line_we),
        .wr_idx_i  (mem_addr_q[IDX_W-1:0]),
        .wr_tag_i  (mem_addr_q[ADDR_W-1:IDX_W]),
        .wr_data_i (line_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DC_IDLE: begin
                if (cpu_write) begin
                    state_d = DC_WRITE;
                end else if (cpu_read && !hit) begin
                    state_d = DC_RMISS;
                end
            end
            DC_RMISS: if (mem_ready) state_d = DC_IDLE;
            DC_WRITE: if (mem_ready) state_d = DC_DONE;
            DC_DONE:  state_d = DC_IDLE;
            default:  state_d = DC_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall  = 1'b0;
        cpu_rdata  = '0;
        line_we    = 1'b0;
        line_wdata = mem_rdata;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        count_hit  = 1'b0;
        case (state_q)
            DC_IDLE: begin
                if (cpu_write) begin
                    cpu_stall = 1'b1;
                    issue_wr  = 1'b1;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_rdata = line_data;
                        count_hit = 1'b1;
                    end else begin
                        cpu_stall = 1'b1;
                        issue_rd  = 1'b1;
                    end
                end
            end
            DC_RMISS: begin
                cpu_stall = 1'b1;
                line_we   = mem_ready;
            end
            DC_WRITE: begin
                // Write-through updates only a line already holding this address.
                cpu_stall  = 1'b1;
                line_we    = mem_ready && hit;
                line_wdata = mem_wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            if (issue_wr) begin
                mem_write_q <= 1'b1;
                mem_addr_q  <= cpu_addr;
                mem_wdata_q <= cpu_wdata;
            end else if (issue_rd) begin
                mem_read_q <= 1'b1;
                mem_addr_q <= cpu_addr;
            end
            if (state_q == DC_RMISS && mem_ready) mem_read_q <= 1'b0;
            if (state_q == DC_WRITE && mem_ready) mem_write_q <= 1'b0;
            if (count_hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_ONE;
            if (issue_rd && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_ONE;
        end
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_dcache_wt_ctrl.sv
// Bench for dcache_wt_ctrl: transaction-level cache model, latency-programmable
// memory responder, per-cycle output checker and literal pins on the model.
module tb_dcache_wt_ctrl;

    logic        clk;
    logic        rst_n;
    logic [6:0]  cpu_addr;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_read;
    logic        mem_write;
    logic [6:0]  mem_addr_o;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    dcache_wt_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr_o(mem_addr_o),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory and cache model ----------------
    logic [31:0] m_mem [128];
    bit   [7:0]  m_valid;
    logic [3:0]  m_tag [8];
    int          m_hit, m_miss;
    logic [31:0] exp_q [$];

    logic [6:0]  cur_addr;
    logic [31:0] cur_wdata;
    int          mem_lat;
    int          rd_served, wr_served;
    logic [6:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    bit          force_ready;
    bit          chk_en;

    // Memory answers mem_lat cycles after it first sees a request.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
            if (mem_read || mem_write) begin
                if (wait_cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    wait_cnt  = 0;
                    if (mem_read) begin
                        mem_rdata = m_mem[mem_addr_o];
                        rd_served++;
                    end else begin
                        last_wr_addr = mem_addr_o;
                        last_wr_data = mem_wdata;
                        wr_served++;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            if (force_ready) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end
        end
    end

    // ---------------- per-cycle checker ----------------
    initial begin
        wait (chk_en);
        forever begin
            @(negedge clk);
            check("mem_rd_wr_excl", 32'(mem_read && mem_write), 32'h0);
            if (mem_read || mem_write) check("mem_addr", 32'(mem_addr_o), 32'(cur_addr));
            if (mem_write) check("mem_wdata", mem_wdata, cur_wdata);
            if (!cpu_read && !cpu_write) begin
                check("idle_stall", 32'(cpu_stall), 32'h0);
                check("idle_rdata", cpu_rdata, 32'h0);
            end
        end
    end

    // ---------------- driver tasks (called just after a rising edge) ----------------
    task automatic do_read(input logic [6:0] a, input int lat, output int stalls, output logic [31:0] rdata);
        bit hit_e;
        int rd0;
        hit_e = m_valid[a[2:0]] && (m_tag[a[2:0]] == a[6:3]);
        rd0 = rd_served;
        mem_lat = lat;
        cur_addr = a;
        exp_q.push_back(m_mem[a]);
        cpu_addr = a;
        cpu_read = 1'b1;
        cpu_write = 1'b0;
        stalls = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        check("rd_stall_cycles", 32'(stalls), hit_e ? 32'h0 : 32'(lat + 2));
        rdata = cpu_rdata;
        check("rd_data", rdata, exp_q.pop_front());
        check("rd_mem_reads", 32'(rd_served - rd0), hit_e ? 32'h0 : 32'h1);
        if (!hit_e) begin
            m_valid[a[2:0]] = 1'b1;
            m_tag[a[2:0]] = a[6:3];
            m_miss++;
        end
        m_hit++;
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        check("rd_hit_cnt", 32'(hit_cnt), 32'(m_hit));
        check("rd_miss_cnt", 32'(miss_cnt), 32'(m_miss));
    endtask

    task automatic do_write(input logic [6:0] a, input logic [31:0] d, input int lat,
                            input bit also_read, output int stalls);
        bit hit_e;
        int wr0, rd0;
        hit_e = m_valid[a[2:0]] && (m_tag[a[2:0]] == a[6:3]);
        wr0 = wr_served;
        rd0 = rd_served;
        mem_lat = lat;
        cur_addr = a;
        cur_wdata = d;
        cpu_addr = a;
        cpu_wdata = d;
        cpu_write = 1'b1;
        cpu_read = also_read;
        stalls = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        check("wr_stall_cycles", 32'(stalls), 32'(lat + 2));
        check("wr_mem_writes", 32'(wr_served - wr0), 32'h1);
        check("wr_mem_reads", 32'(rd_served - rd0), 32'h0);
        check("wr_mem_addr", 32'(last_wr_addr), 32'(a));
        check("wr_mem_data", last_wr_data, d);
        m_mem[a] = d;
        @(posedge clk);
        #1;
        cpu_write = 1'b0;
        cpu_read = 1'b0;
        check("wr_hit_cnt", 32'(hit_cnt), 32'(m_hit));
        check("wr_miss_cnt", 32'(miss_cnt), 32'(m_miss));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          st;
        logic [31:0] rd;

        for (int i = 0; i < 128; i++) m_mem[i] = 32'hA5000000 | 32'(i);
        m_mem[7'h15] = 32'hDEADBEEF;
        m_mem[7'h1D] = 32'hCAFEF00D;
        m_valid = '0;
        m_hit = 0;
        m_miss = 0;
        rd_served = 0;
        wr_served = 0;
        mem_lat = 1;
        force_ready = 1'b0;
        chk_en = 1'b0;
        cur_addr = '0;
        cur_wdata = '0;
        last_wr_addr = '0;
        last_wr_data = '0;
        cpu_addr = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_wdata = '0;
        rst_n = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_read", 32'(mem_read), 32'h0);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_mem_addr", 32'(mem_addr_o), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'h0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'h0);
        check("rst_stall", 32'(cpu_stall), 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Cold read: memory latency 3 gives 5 stall cycles.
        do_read(7'h15, 3, st, rd);
        check("cold_stall_lit", 32'(st), 32'd5);
        check("cold_data_lit", rd, 32'hDEADBEEF);
        check("cold_cnt_lit", {16'(hit_cnt), 16'(miss_cnt)}, {16'd1, 16'd1});

        do_read(7'h15, 3, st, rd);
        check("rehit_stall_lit", 32'(st), 32'd0);
        check("rehit_data_lit", rd, 32'hDEADBEEF);
        check("rehit_hits_lit", 32'(hit_cnt), 32'd2);

        // Same index 5, different tag: conflict eviction.
        do_read(7'h1D, 2, st, rd);
        check("conflict_data_lit", rd, 32'hCAFEF00D);
        do_read(7'h15, 1, st, rd);
        check("conflict_miss_lit", 32'(miss_cnt), 32'd3);

        do_write(7'h15, 32'h12345678, 2, 1'b0, st);
        check("wr_hit_stall_lit", 32'(st), 32'd4);
        do_read(7'h15, 1, st, rd);
        check("wr_hit_read_lit", rd, 32'h12345678);
        check("wr_hit_read_stall_lit", 32'(st), 32'd0);

        // Store to an uncached line with a read also asserted: store wins, no allocate.
        do_write(7'h40, 32'h0BADCAFE, 1, 1'b1, st);
        do_read(7'h40, 2, st, rd);
        check("wr_miss_read_stall_lit", 32'(st), 32'd4);
        check("wr_miss_read_data_lit", rd, 32'h0BADCAFE);

        do_read(7'h1D, 1, st, rd);
        do_read(7'h1D, 1, st, rd);

        // Reset while a read miss is outstanding.
        mem_lat = 10;
        cur_addr = 7'h22;
        cpu_addr = 7'h22;
        cpu_read = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_mem_read", 32'(mem_read), 32'h1);
        check("pre_rst_stall", 32'(cpu_stall), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_read", 32'(mem_read), 32'h0);
        check("async_rst_hit_cnt", 32'(hit_cnt), 32'h0);
        check("async_rst_miss_cnt", 32'(miss_cnt), 32'h0);
        check("async_rst_mem_addr", 32'(mem_addr_o), 32'h0);
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_valid = '0;
        m_hit = 0;
        m_miss = 0;

        force_ready = 1'b1;
        @(posedge clk);
        #1;
        force_ready = 1'b0;
        @(posedge clk);
        #1;
        check("stray_ready_mem_read", 32'(mem_read), 32'h0);
        check("stray_ready_mem_write", 32'(mem_write), 32'h0);
        check("stray_ready_cnts", {16'(hit_cnt), 16'(miss_cnt)}, 32'h0);

        // All lines were invalidated, so a previously cached address misses.
        do_read(7'h15, 2, st, rd);
        check("post_rst_stall_lit", 32'(st), 32'd4);
        check("post_rst_data_lit", rd, 32'h12345678);
        check("post_rst_cnt_lit", {16'(hit_cnt), 16'(miss_cnt)}, {16'd1, 16'd1});

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
